// File: rtl/pe_dbuf.sv
// Systolic processing element with double-buffered weights, valid-qualified dataflow,
// signed/unsigned operands, optional saturating add and a local-accumulate mode.
module pe_dbuf #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode_acc,
  input  logic                  signed_en,
  input  logic                  wt_shift,
  input  logic                  wt_swap,
  input  logic [DATA_WIDTH-1:0] weight_in,
  output logic [DATA_WIDTH-1:0] weight_out,
  input  logic [DATA_WIDTH-1:0] act_in,
  input  logic                  act_valid_in,
  output logic [DATA_WIDTH-1:0] act_out,
  output logic                  act_valid_out,
  input  logic [ACC_WIDTH-1:0]  psum_in,
  input  logic                  psum_valid_in,
  output logic [ACC_WIDTH-1:0]  psum_out,
  output logic                  psum_valid_out,
  input  logic                  acc_clear,
  input  logic                  acc_drain,
  output logic                  sat_flag
);

  logic [DATA_WIDTH-1:0]         shadow_q;
  logic [DATA_WIDTH-1:0]         w_act_q;
  logic [ACC_WIDTH-1:0]          acc_q;

  logic signed [DATA_WIDTH:0]    a_ext;
  logic signed [DATA_WIDTH:0]    w_ext;
  logic signed [2*DATA_WIDTH+1:0] prod_full;
  logic [ACC_WIDTH-1:0]          prod;
  logic [ACC_WIDTH-1:0]          addend;
  logic [ACC_WIDTH:0]            sum_ext;
  logic [ACC_WIDTH-1:0]          add_res;
  logic                          add_ovf;

  // One extra bit carries the operand sign (or 0 when unsigned), so one signed multiply serves both modes.
  assign a_ext     = {signed_en & act_in[DATA_WIDTH-1], act_in};
  assign w_ext     = {signed_en & w_act_q[DATA_WIDTH-1], w_act_q};
  assign prod_full = a_ext * w_ext;
  assign prod      = ACC_WIDTH'(prod_full);

  // A single adder is shared: the accumulator in local mode, the incoming psum otherwise.
  assign addend  = mode_acc ? acc_q : psum_in;
  assign sum_ext = {signed_en & addend[ACC_WIDTH-1], addend}
                 + {signed_en & prod[ACC_WIDTH-1], prod};

  always_comb begin
    add_res = sum_ext[ACC_WIDTH-1:0];
    add_ovf = 1'b0;
    if (SATURATE) begin
      if (signed_en) begin
        if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]) begin
          add_ovf = 1'b1;
          add_res = sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
      end else if (sum_ext[ACC_WIDTH]) begin
        add_ovf = 1'b1;
        add_res = '1;
      end
    end
  end

  assign weight_out = shadow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q       <= '0;
      w_act_q        <= '0;
      acc_q          <= '0;
      act_out        <= '0;
      act_valid_out  <= 1'b0;
      psum_out       <= '0;
      psum_valid_out <= 1'b0;
      sat_flag       <= 1'b0;
    end else begin
      if (wt_shift) shadow_q <= weight_in;
      if (wt_swap)  w_act_q  <= shadow_q;

      act_out       <= act_in;
      act_valid_out <= act_valid_in;

      if (!mode_acc) begin
        if (act_valid_in) begin
          psum_out       <= add_res;
          psum_valid_out <= 1'b1;
          if (add_ovf) sat_flag <= 1'b1;
        end else begin
          psum_valid_out <= 1'b0;
        end
      end else if (acc_clear) begin
        acc_q          <= '0;
        sat_flag       <= 1'b0;
        psum_valid_out <= 1'b0;
      end else if (acc_drain) begin
        psum_out       <= acc_q;
        psum_valid_out <= 1'b1;
        acc_q          <= act_valid_in ? prod : '0;
      end else begin
        if (act_valid_in) begin
          acc_q <= add_res;
          if (add_ovf) sat_flag <= 1'b1;
        end
        psum_out       <= psum_in;
        psum_valid_out <= psum_valid_in;
      end
    end
  end

endmodule
